// File: rtl/ok_bridge_pkg.sv
// Shared types and constants for the FrontPanel wire-level handshake bridge.
// Holds the path FSM encodings, wo_status bit positions and the FPGATop endpoint map.
package ok_bridge_pkg;

    typedef enum logic {
        E_EMPTY = 1'b0,
        E_FULL  = 1'b1
    } enq_state_e;

    typedef enum logic {
        D_EMPTY = 1'b0,
        D_FULL  = 1'b1
    } deq_state_e;

    localparam int STATUS_OVF_BIT = 31;
    localparam int STATUS_UNF_BIT = 30;

    // okWireIn / okWireOut endpoint addresses wired up by FPGATop
    localparam logic [7:0] EP_ENQ_VALID   = 8'h03;
    localparam logic [7:0] EP_ENQ_BITS_LO = 8'h04;
    localparam logic [7:0] EP_ENQ_BITS_HI = 8'h05;
    localparam logic [7:0] EP_IN_VALID    = 8'h06;
    localparam logic [7:0] EP_IN_BITS     = 8'h07;
    localparam logic [7:0] EP_DEQ         = 8'h08;
    localparam logic [7:0] EP_WO_FIRST    = 8'h20;
    localparam logic [7:0] EP_WO_LAST     = 8'h23;

endpackage

// File: rtl/ok_level_to_pulse.sv
// Turns a host level wire into a single-cycle pulse on each rising edge.
// The previous-sample register resets to 0, so a wire already high at release yields one pulse.
module ok_level_to_pulse (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/ok_wire_handshake_bridge.sv
// Bridges host toggle wires to ready/valid transfers in both directions, one beat per toggle,
// and reports counters plus sticky overflow/underflow flags through wire-outs.
module ok_wire_handshake_bridge
    import ok_bridge_pkg::*;
#(
    parameter int IN_WORDS  = 2,
    parameter int OUT_WORDS = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wi_enq_valid,
    input  logic [32*IN_WORDS-1:0]  wi_enq_bits,
    output logic                    wo_enq_ready,
    output logic                    enq_valid,
    input  logic                    enq_ready,
    output logic [32*IN_WORDS-1:0]  enq_bits,
    input  logic                    deq_valid,
    output logic                    deq_ready,
    input  logic [32*OUT_WORDS-1:0] deq_bits,
    output logic                    wo_deq_valid,
    output logic [32*OUT_WORDS-1:0] wo_deq_bits,
    input  logic                    wi_deq,
    output logic [31:0]             wo_status,
    output logic [CNT_W-1:0]        wo_deq_count,
    input  logic                    wi_clear
);

    // Handshake: a beat moves on any rising clock where valid and ready are both 1;
    // valid never drops and the data never changes while a beat waits for ready.

    logic enq_rise;
    logic deq_rise;

    ok_level_to_pulse u_enq_edge (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .level_i   (wi_enq_valid),
        .pulse_o   (enq_rise)
    );

    ok_level_to_pulse u_deq_edge (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .level_i   (wi_deq),
        .pulse_o   (deq_rise)
    );

    enq_state_e enq_state_q, enq_state_d;
    deq_state_e deq_state_q, deq_state_d;

    logic [32*IN_WORDS-1:0]  hold_in_q, hold_in_d;
    logic [32*OUT_WORDS-1:0] hold_out_q, hold_out_d;
    logic [CNT_W-1:0]        enq_count_q, enq_count_d;
    logic [CNT_W-1:0]        deq_count_q, deq_count_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    logic enq_capture, enq_done, ovf_set;
    logic deq_capture, deq_pop, unf_set;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enq_state_q <= E_EMPTY;
            deq_state_q <= D_EMPTY;
        end else begin
            enq_state_q <= enq_state_d;
            deq_state_q <= deq_state_d;
        end
    end

    // A handshake and a new rise in the same cycle refill the register without passing through empty
    always_comb begin
        enq_state_d = enq_state_q;
        enq_capture = 1'b0;
        enq_done    = 1'b0;
        ovf_set     = 1'b0;
        case (enq_state_q)
            E_EMPTY: begin
                if (enq_rise) begin
                    enq_capture = 1'b1;
                    enq_state_d = E_FULL;
                end
            end
            E_FULL: begin
                enq_done = enq_ready;
                if (enq_ready && enq_rise) begin
                    enq_capture = 1'b1;
                end else if (enq_ready) begin
                    enq_state_d = E_EMPTY;
                end else if (enq_rise) begin
                    ovf_set = 1'b1;
                end
            end
            default: enq_state_d = E_EMPTY;
        endcase
    end

    always_comb begin
        deq_state_d = deq_state_q;
        deq_capture = 1'b0;
        deq_pop     = 1'b0;
        unf_set     = 1'b0;
        case (deq_state_q)
            D_EMPTY: begin
                unf_set = deq_rise;
                if (deq_valid) begin
                    deq_capture = 1'b1;
                    deq_state_d = D_FULL;
                end
            end
            D_FULL: begin
                if (deq_rise) begin
                    deq_pop     = 1'b1;
                    deq_state_d = D_EMPTY;
                end
            end
            default: deq_state_d = D_EMPTY;
        endcase
    end

    // Clear takes priority over any increment or flag set in the same cycle
    always_comb begin
        hold_in_d   = enq_capture ? wi_enq_bits : hold_in_q;
        hold_out_d  = deq_capture ? deq_bits : hold_out_q;
        enq_count_d = enq_count_q + CNT_W'(enq_done);
        deq_count_d = deq_count_q + CNT_W'(deq_pop);
        ovf_d       = ovf_q | ovf_set;
        unf_d       = unf_q | unf_set;
        if (wi_clear) begin
            enq_count_d = '0;
            deq_count_d = '0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_in_q   <= '0;
            hold_out_q  <= '0;
            enq_count_q <= '0;
            deq_count_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            hold_in_q   <= hold_in_d;
            hold_out_q  <= hold_out_d;
            enq_count_q <= enq_count_d;
            deq_count_q <= deq_count_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    always_comb begin
        enq_valid                 = (enq_state_q == E_FULL);
        wo_enq_ready              = (enq_state_q == E_EMPTY);
        enq_bits                  = hold_in_q;
        deq_ready                 = (deq_state_q == D_EMPTY);
        wo_deq_valid              = (deq_state_q == D_FULL);
        wo_deq_bits               = hold_out_q;
        wo_deq_count              = deq_count_q;
        wo_status                 = 32'(enq_count_q);
        wo_status[STATUS_OVF_BIT] = ovf_q;
        wo_status[STATUS_UNF_BIT] = unf_q;
    end

endmodule

// File: tb/tb_ok_wire_handshake_bridge.sv
// Bench for ok_wire_handshake_bridge: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based model of the host/emulator exchange.
module tb_ok_wire_handshake_bridge;

    localparam int IN_W  = 64;
    localparam int OUT_W = 32;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             wi_enq_valid = 1'b0;
    logic [IN_W-1:0]  wi_enq_bits = '0;
    logic             wo_enq_ready;
    logic             enq_valid;
    logic             enq_ready = 1'b0;
    logic [IN_W-1:0]  enq_bits;
    logic             deq_valid = 1'b0;
    logic             deq_ready;
    logic [OUT_W-1:0] deq_bits = '0;
    logic             wo_deq_valid;
    logic [OUT_W-1:0] wo_deq_bits;
    logic             wi_deq = 1'b0;
    logic [31:0]      wo_status;
    logic [CNT_W-1:0] wo_deq_count;
    logic             wi_clear = 1'b0;

    always #5 clock = ~clock;

    ok_wire_handshake_bridge #(.IN_WORDS(2), .OUT_WORDS(1), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wi_enq_valid (wi_enq_valid),
        .wi_enq_bits  (wi_enq_bits),
        .wo_enq_ready (wo_enq_ready),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_bits     (enq_bits),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_bits     (deq_bits),
        .wo_deq_valid (wo_deq_valid),
        .wo_deq_bits  (wo_deq_bits),
        .wi_deq       (wi_deq),
        .wo_status    (wo_status),
        .wo_deq_count (wo_deq_count),
        .wi_clear     (wi_clear)
    );

    // ---------------- behavioural model ----------------
    logic [IN_W-1:0]  exp_q[$];
    logic [IN_W-1:0]  m_last_in;
    logic [OUT_W-1:0] out_q[$];
    logic [OUT_W-1:0] m_last_out;
    logic             m_ovf, m_unf;
    logic [CNT_W-1:0] m_ecnt, m_dcnt;
    logic             m_seen_ev, m_seen_dq;

    always @(posedge clock or negedge reset_n) begin
        bit er, dr, hs, out_full;
        if (!reset_n) begin
            exp_q.delete();
            out_q.delete();
            m_last_in  = '0;
            m_last_out = '0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_ecnt     = '0;
            m_dcnt     = '0;
            m_seen_ev  = 1'b0;
            m_seen_dq  = 1'b0;
        end else begin
            er       = wi_enq_valid && !m_seen_ev;
            dr       = wi_deq && !m_seen_dq;
            hs       = (exp_q.size() != 0) && enq_ready;
            out_full = (out_q.size() != 0);
            if (exp_q.size() != 0 && er && !hs) m_ovf = 1'b1;
            if (hs) begin
                void'(exp_q.pop_front());
                m_ecnt = m_ecnt + 1'b1;
            end
            if (er && exp_q.size() == 0) begin
                exp_q.push_back(wi_enq_bits);
                m_last_in = wi_enq_bits;
            end
            if (!out_full && dr) m_unf = 1'b1;
            if (out_full && dr) begin
                void'(out_q.pop_front());
                m_dcnt = m_dcnt + 1'b1;
            end
            if (!out_full && deq_valid) begin
                out_q.push_back(deq_bits);
                m_last_out = deq_bits;
            end
            if (wi_clear) begin
                m_ovf  = 1'b0;
                m_unf  = 1'b0;
                m_ecnt = '0;
                m_dcnt = '0;
            end
            m_seen_ev = wi_enq_valid;
            m_seen_dq = wi_deq;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    int checks = 0;
    int errors = 0;

    string       pin_name = "";
    logic [7:0]  pin_mask = '0;
    int          pin_seq = 0;
    int          seen_seq = 0;
    logic             pe_enq_valid, pe_wo_enq_ready, pe_deq_ready, pe_wo_deq_valid;
    logic [IN_W-1:0]  pe_enq_bits;
    logic [OUT_W-1:0] pe_wo_deq_bits;
    logic [31:0]      pe_status;
    logic [CNT_W-1:0] pe_deq_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [31:0] m_status;
        m_status = 32'(m_ecnt);
        m_status[31] = m_ovf;
        m_status[30] = m_unf;
        chk("enq_valid",    64'(enq_valid),    64'(exp_q.size() != 0));
        chk("wo_enq_ready", 64'(wo_enq_ready), 64'(exp_q.size() == 0));
        chk("enq_bits",     enq_bits,          m_last_in);
        chk("deq_ready",    64'(deq_ready),    64'(out_q.size() == 0));
        chk("wo_deq_valid", 64'(wo_deq_valid), 64'(out_q.size() != 0));
        chk("wo_deq_bits",  64'(wo_deq_bits),  64'(m_last_out));
        chk("wo_status",    64'(wo_status),    64'(m_status));
        chk("wo_deq_count", 64'(wo_deq_count), 64'(m_dcnt));
        if (pin_seq != seen_seq) begin
            seen_seq = pin_seq;
            if (pin_mask[0]) chk({pin_name, ".enq_valid"},    64'(enq_valid),    64'(pe_enq_valid));
            if (pin_mask[1]) chk({pin_name, ".wo_enq_ready"}, 64'(wo_enq_ready), 64'(pe_wo_enq_ready));
            if (pin_mask[2]) chk({pin_name, ".enq_bits"},     enq_bits,          pe_enq_bits);
            if (pin_mask[3]) chk({pin_name, ".deq_ready"},    64'(deq_ready),    64'(pe_deq_ready));
            if (pin_mask[4]) chk({pin_name, ".wo_deq_valid"}, 64'(wo_deq_valid), 64'(pe_wo_deq_valid));
            if (pin_mask[5]) chk({pin_name, ".wo_deq_bits"},  64'(wo_deq_bits),  64'(pe_wo_deq_bits));
            if (pin_mask[6]) chk({pin_name, ".wo_status"},    64'(wo_status),    64'(pe_status));
            if (pin_mask[7]) chk({pin_name, ".wo_deq_count"}, 64'(wo_deq_count), 64'(pe_deq_count));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pin_go(input string name, input logic [7:0] mask);
        pin_name = name;
        pin_mask = mask;
        pin_seq++;
    endtask

    task automatic pin_reset_values(input string name);
        pe_enq_valid    = 1'b0;
        pe_wo_enq_ready = 1'b1;
        pe_enq_bits     = '0;
        pe_deq_ready    = 1'b1;
        pe_wo_deq_valid = 1'b0;
        pe_wo_deq_bits  = '0;
        pe_status       = '0;
        pe_deq_count    = '0;
        pin_go(name, 8'hFF);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc(2);
        pin_reset_values("reset");
        reset_n = 1'b1;
        cyc(1);

        // single enqueue with ready high
        enq_ready    = 1'b1;
        wi_enq_bits  = 64'h00000080_00000001;
        wi_enq_valid = 1'b1;
        cyc(1);
        pe_enq_valid = 1'b1; pe_wo_enq_ready = 1'b0; pe_enq_bits = 64'h00000080_00000001;
        pin_go("enq_first", 8'h07);
        wi_enq_valid = 1'b0;
        cyc(1);
        pe_enq_valid = 1'b0; pe_wo_enq_ready = 1'b1; pe_status = 32'h0000_0001;
        pin_go("enq_done", 8'h47);
        cyc(1);

        // overflow while the held beat is stalled
        wi_clear = 1'b1;
        cyc(1);
        wi_clear = 1'b0;
        enq_ready = 1'b0;
        wi_enq_bits = 64'h4; wi_enq_valid = 1'b1;
        cyc(1);
        wi_enq_valid = 1'b0;
        cyc(1);
        wi_enq_bits = 64'h8; wi_enq_valid = 1'b1;
        cyc(1);
        wi_enq_valid = 1'b0;
        pe_enq_valid = 1'b1; pe_enq_bits = 64'h4; pe_status = 32'h8000_0000;
        pin_go("overflow", 8'h45);
        cyc(1);
        enq_ready = 1'b1;
        cyc(1);
        pe_enq_valid = 1'b0; pe_status = 32'h8000_0001;
        pin_go("overflow_drain", 8'h41);
        cyc(1);

        // a level held high for 20 cycles is one enqueue
        wi_clear = 1'b1;
        cyc(1);
        wi_clear = 1'b0;
        wi_enq_bits = 64'h55; wi_enq_valid = 1'b1;
        cyc(20);
        wi_enq_valid = 1'b0;
        cyc(1);
        pe_enq_valid = 1'b0; pe_status = 32'h0000_0001;
        pin_go("held_level", 8'h41);
        cyc(1);

        // dequeue path: fill, pop, refill one cycle later
        deq_bits = 32'h9; deq_valid = 1'b1;
        cyc(1);
        pe_wo_deq_valid = 1'b1; pe_wo_deq_bits = 32'h9; pe_deq_ready = 1'b0;
        pin_go("deq_fill", 8'h38);
        deq_bits = 32'hA; wi_deq = 1'b1;
        cyc(1);
        pe_wo_deq_valid = 1'b0; pe_deq_ready = 1'b1; pe_deq_count = 16'd1;
        pin_go("deq_pop", 8'h98);
        wi_deq = 1'b0;
        cyc(1);
        pe_wo_deq_valid = 1'b1; pe_wo_deq_bits = 32'hA;
        pin_go("deq_refill", 8'h30);
        deq_valid = 1'b0; wi_deq = 1'b1;
        cyc(1);
        wi_deq = 1'b0;
        cyc(1);

        // underflow, then clear
        wi_deq = 1'b1;
        cyc(1);
        wi_deq = 1'b0;
        pe_status = 32'h4000_0001; pe_deq_count = 16'd2;
        pin_go("underflow", 8'hC0);
        wi_clear = 1'b1;
        cyc(1);
        wi_clear = 1'b0;
        pe_status = 32'h0; pe_deq_count = 16'd0;
        pin_go("clear", 8'hC0);
        cyc(1);

        // asynchronous reset with both holding registers full
        enq_ready = 1'b0;
        wi_enq_bits = 64'h77; wi_enq_valid = 1'b1;
        cyc(1);
        deq_bits = 32'h33; deq_valid = 1'b1;
        cyc(1);
        deq_valid = 1'b0;
        pe_enq_valid = 1'b1; pe_enq_bits = 64'h77; pe_wo_deq_valid = 1'b1; pe_wo_deq_bits = 32'h33;
        pin_go("both_full", 8'h35);
        cyc(1);
        reset_n = 1'b0;
        pin_reset_values("async_reset");
        cyc(1);
        wi_deq = 1'b1;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        pe_enq_valid = 1'b1; pe_enq_bits = 64'h77; pe_wo_deq_valid = 1'b0; pe_status = 32'h4000_0000;
        pin_go("release_rise", 8'h55);
        cyc(3);
        pin_go("release_single", 8'h41);
        enq_ready = 1'b1;
        cyc(1);
        pe_enq_valid = 1'b0; pe_status = 32'h4000_0001;
        pin_go("release_drain", 8'h41);
        wi_enq_valid = 1'b0; wi_deq = 1'b0;
        cyc(1);

        // random traffic on both paths
        for (int i = 0; i < 1500; i++) begin
            enq_ready = ($urandom_range(0, 3) != 0);
            if (!wi_enq_valid) begin
                wi_enq_bits  = {$urandom(), $urandom()};
                wi_enq_valid = ($urandom_range(0, 2) == 0);
            end else begin
                wi_enq_valid = ($urandom_range(0, 1) == 0);
            end
            deq_valid = ($urandom_range(0, 1) == 0);
            deq_bits  = $urandom();
            wi_deq    = ($urandom_range(0, 2) == 0);
            wi_clear  = ($urandom_range(0, 40) == 0);
            cyc(1);
        end
        wi_clear = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
